reg8_load_arbiter: RTL and testbench

Round-robin arbiter and load sequencer that shares one parallel-load register (8-bit default) among N requesters. It drives the register's PL strobe and data input, returns a one-cycle grant to the winning requester, and enforces a guard interval between loads. It sits between requesting blocks and the register instance; the register's clk is the same clk.

---
 rtl/reg8_load_arbiter_if.sv | 25 ++
 rtl/reg8_load_arbiter.sv | 70 +++++++
 tb/tb_reg8_load_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/reg8_load_arbiter_if.sv
// reg8_load_arbiter_if: request/grant and register-load bundle between requesters and the arbiter
//   en     arbitration enable (requester side drives)
//   req    per-requester request bits
//   data   packed write data, requester i at [i*W +: W]
//   gnt    one-hot grant pulse during LOAD
//   pl     parallel-load strobe to the shared register
//   di_out data presented to the register
//   owner  id of the most recently granted requester
//   busy   high while LOAD or GUARD is in progress
interface reg8_load_arbiter_if #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
);
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic           pl;
    logic [W-1:0]   di_out;
    logic [IDW-1:0] owner;
    logic           busy;
    modport master(output en, req, data, input gnt, pl, di_out, owner, busy);
    modport slave(input en, req, data, output gnt, pl, di_out, owner, busy);
endinterface

// File: rtl/reg8_load_arbiter.sv
// reg8_load_arbiter: round-robin arbiter sequencing loads of one shared parallel-load register
//   clk    rising-edge clock shared with the register
//   rst_n  synchronous active-low reset
//   bus    slave side of reg8_load_arbiter_if (en/req/data in; gnt/pl/di_out/owner/busy out)
module reg8_load_arbiter #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int IDW   = 2,
    parameter int GUARD = 1
) (
    input logic               clk,
    input logic               rst_n,
    reg8_load_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, GUARD_ST} state_t;
    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, win, owner_q;
    logic [W-1:0]   di_q;
    logic [3:0]     cnt;
    logic           found, take;

    // ptr and k are both below N, so one conditional subtract is a full mod-N wrap
    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v >= N ? v - N : v);
    endfunction

    // first requester at or after ptr, ascending with wrap
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req[wrap(int'(ptr) + k)]) begin
                found = 1'b1;
                win   = wrap(int'(ptr) + k);
            end
        end
    end

    always_comb begin
        take      = (state == IDLE) && bus.en && found;
        state_nxt = (state == IDLE) ? (take ? LOAD : IDLE) :
                    (state == LOAD) ? GUARD_ST :
                    (cnt == 4'd0)   ? IDLE : GUARD_ST;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            di_q    <= '0;
            owner_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == LOAD) ? 4'(GUARD - 1) : (state == GUARD_ST) ? cnt - 4'd1 : cnt;
            if (take) begin
                di_q    <= bus.data[win*W +: W];
                owner_q <= win;
                ptr     <= wrap(int'(win) + 1);
            end
        end
    end

    // Moore outputs: decoded only from registered state and owner
    assign bus.pl     = (state == LOAD);
    assign bus.busy   = (state != IDLE);
    assign bus.gnt    = (state == LOAD) ? N'(1) << owner_q : '0;
    assign bus.di_out = di_q;
    assign bus.owner  = owner_q;
endmodule

// File: tb/tb_reg8_load_arbiter.sv
// tb_reg8_load_arbiter: scoreboard bench for reg8_load_arbiter with GUARD=1 and GUARD=4 instances
module tb_reg8_load_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg8_load_arbiter_if #(.N(4), .W(8), .IDW(2)) a();
    reg8_load_arbiter_if #(.N(4), .W(8), .IDW(2)) b();

    reg8_load_arbiter #(.N(4), .W(8), .IDW(2), .GUARD(1)) dut_a(.clk(clk), .rst_n(rst_n), .bus(a));
    reg8_load_arbiter #(.N(4), .W(8), .IDW(2), .GUARD(4)) dut_b(.clk(clk), .rst_n(rst_n), .bus(b));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_a = -1, last_b = -1;
    int gap_a = 0;
    int run_a = 0, run_b = 0;
    logic auto_a = 1'b1;
    logic [7:0] reg_a;
    logic [13:0] qa[$];
    logic [13:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] ev(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o);
        return {g, d, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a.pl) reg_a <= a.di_out;
    end

    // requester A contract: drop a request once its grant is seen
    always @(negedge clk) if (auto_a) a.req = a.req & ~a.gnt;

    // monitor A
    always @(negedge clk) begin
        if (a.pl) begin
            logic has;
            has = qa.size() != 0;
            chk("pending_a", 32'(has), 32'd1);
            if (has) chk("grant_a", 32'({a.gnt, a.di_out, a.owner}), 32'(qa.pop_front()));
            if (gap_a != 0 && last_a >= 0) chk("gap_a", 32'(cyc - last_a), 32'(gap_a));
            last_a = cyc;
        end
        if (!rst_n) run_a = 0;
        else if (a.busy) run_a++;
        else if (run_a != 0) begin
            chk("busy_len_a", 32'(run_a), 32'd2);
            run_a = 0;
        end
    end

    // monitor B
    always @(negedge clk) begin
        if (b.pl) begin
            logic has;
            has = qb.size() != 0;
            chk("pending_b", 32'(has), 32'd1);
            if (has) chk("grant_b", 32'({b.gnt, b.di_out, b.owner}), 32'(qb.pop_front()));
            if (last_b >= 0) chk("gap_b", 32'(cyc - last_b), 32'd6);
            last_b = cyc;
        end
        if (!rst_n) run_b = 0;
        else if (b.busy) run_b++;
        else if (run_b != 0) begin
            chk("busy_len_b", 32'(run_b), 32'd5);
            run_b = 0;
        end
    end

    task automatic drain_a();
        for (int k = 0; k < 60 && (qa.size() != 0 || a.busy); k++) tick();
        chk("drain_a", 32'(qa.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        a.en = 1'b1; a.req = '0; a.data = '0;
        b.en = 1'b1; b.req = '0; b.data = '0;
        repeat (2) tick();
        chk("rst_pl", 32'(a.pl), 32'd0);
        chk("rst_gnt", 32'(a.gnt), 32'd0);
        chk("rst_busy", 32'(a.busy), 32'd0);
        chk("rst_di", 32'(a.di_out), 32'd0);
        chk("rst_owner", 32'(a.owner), 32'd0);
        rst_n = 1'b1;
        tick();

        // all four requesting continuously from ptr=0
        a.data = {8'h13, 8'h12, 8'h11, 8'h10};
        auto_a = 1'b0;
        gap_a = 3;
        last_a = -1;
        qa.push_back(ev(4'b0001, 8'h10, 2'd0));
        qa.push_back(ev(4'b0010, 8'h11, 2'd1));
        qa.push_back(ev(4'b0100, 8'h12, 2'd2));
        qa.push_back(ev(4'b1000, 8'h13, 2'd3));
        qa.push_back(ev(4'b0001, 8'h10, 2'd0));
        a.req = 4'b1111;
        n = 0;
        for (int k = 0; k < 40 && n < 5; k++) begin
            tick();
            if (a.pl) n++;
        end
        chk("rr_count", 32'(n), 32'd5);
        a.req = '0;
        drain_a();
        gap_a = 0;
        auto_a = 1'b1;

        // single request, one-cycle decision to LOAD
        a.data[2*8 +: 8] = 8'hAF;
        qa.push_back(ev(4'b0100, 8'hAF, 2'd2));
        a.req = 4'b0100;
        tick();
        chk("t1_pl", 32'(a.pl), 32'd1);
        chk("t1_gnt", 32'(a.gnt), 32'h4);
        tick();
        chk("t1_reg", 32'(reg_a), 32'hAF);
        chk("t1_busy_guard", 32'(a.busy), 32'd1);
        tick();
        chk("t1_busy_idle", 32'(a.busy), 32'd0);

        // ptr=3: requester 3 first, then wrap to 0
        a.data[3*8 +: 8] = 8'h33;
        a.data[0*8 +: 8] = 8'h30;
        qa.push_back(ev(4'b1000, 8'h33, 2'd3));
        qa.push_back(ev(4'b0001, 8'h30, 2'd0));
        a.req = 4'b1001;
        drain_a();
        chk("t3_owner", 32'(a.owner), 32'd0);

        // enable low blocks grants
        a.en = 1'b0;
        a.req = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_pl", 32'(a.pl), 32'd0);
            chk("t4_gnt", 32'(a.gnt), 32'd0);
            chk("t4_busy", 32'(a.busy), 32'd0);
        end
        qa.push_back(ev(4'b0010, 8'h11, 2'd1));
        a.en = 1'b1;
        tick();
        chk("t4_gnt_en", 32'(a.gnt), 32'h2);
        drain_a();

        // reset during LOAD, then ptr restarts at 0
        qa.push_back(ev(4'b0100, 8'hAF, 2'd2));
        a.req = 4'b0100;
        tick();
        chk("t5_pl_load", 32'(a.pl), 32'd1);
        rst_n = 1'b0;
        a.req = '0;
        tick();
        chk("t5_pl", 32'(a.pl), 32'd0);
        chk("t5_gnt", 32'(a.gnt), 32'd0);
        chk("t5_busy", 32'(a.busy), 32'd0);
        chk("t5_di", 32'(a.di_out), 32'd0);
        chk("t5_owner", 32'(a.owner), 32'd0);
        rst_n = 1'b1;
        qa.push_back(ev(4'b0001, 8'h30, 2'd0));
        qa.push_back(ev(4'b1000, 8'h33, 2'd3));
        a.req = 4'b1001;
        drain_a();
        chk("t5_owner_end", 32'(a.owner), 32'd3);

        // GUARD=4 instance: 6-cycle spacing, data frozen after sampling
        b.data = {16'h0, 8'h51, 8'h50};
        qb.push_back(ev(4'b0001, 8'h50, 2'd0));
        qb.push_back(ev(4'b0010, 8'h51, 2'd1));
        qb.push_back(ev(4'b0001, 8'h50, 2'd0));
        qb.push_back(ev(4'b0010, 8'h51, 2'd1));
        b.req = 4'b0011;
        for (int k = 0; k < 20 && !b.pl; k++) tick();
        chk("t6_first_pl", 32'(b.pl), 32'd1);
        tick();
        b.data[7:0] = 8'h5A;
        tick();
        chk("t6_di_hold", 32'(b.di_out), 32'h50);
        b.data[7:0] = 8'h50;
        n = 1;
        for (int k = 0; k < 60 && n < 4; k++) begin
            tick();
            if (b.pl) n++;
        end
        chk("t6_count", 32'(n), 32'd4);
        b.req = '0;
        for (int k = 0; k < 20 && b.busy; k++) tick();
        tick();
        chk("drain_b", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
